serial_to_parallel_rx: RTL

- Receive side of the team's serial shift link.
- Accepts a qualified serial bit stream, MSB-first or LSB-first selectable per word, and assembles N-bit words.
- Presents each word on a parallel output through a one-entry valid/ready holding buffer.
- Sits between a serial source (transmitting universal shift register or pin) and a parallel consumer; reports overrun when the consumer stalls.

---
 rtl/serial_to_parallel_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_to_parallel_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel_rx
// Description : Receive side of the serial shift link. Assembles N-bit words
//               from a qualified serial stream (MSB- or LSB-first, chosen per
//               word) and presents them through a one-entry valid/ready
//               holding buffer, flagging overrun when the consumer stalls.
//               Optional feature macro: SER_RX_PARITY_EN (adds a trailing
//               even-parity bit per frame and the parity_err output).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_to_parallel_rx #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_in,
    input  logic         s_valid,
    input  logic         msb_first,
    input  logic         flush,
    output logic [N-1:0] p_out,
    output logic         p_valid,
    input  logic         p_ready,
    output logic         busy,
    output logic         overrun
`ifdef SER_RX_PARITY_EN
    ,
    output logic         parity_err
`endif
);

`ifdef SER_RX_PARITY_EN
    localparam int c_FRAME = N + 1;
`else
    localparam int c_FRAME = N;
`endif
    localparam int                 c_CNT_W = $clog2(c_FRAME);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_FRAME - 1);

    logic [N-1:0]       r_sr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ord;
    logic [N-1:0]       r_p_out;
    logic               r_p_valid;
    logic               r_overrun;

    logic               w_accept;
    logic               w_first;
    logic               w_last;
    logic               w_ord;
    logic               w_complete;
    logic               w_drain;
    logic               w_load;
    logic               w_shift_data;
    logic [N-1:0]       w_sr_shifted;
    logic [N-1:0]       w_word;

    // A flushed cycle never consumes its bit.
    assign w_accept   = s_valid & ~flush;
    assign w_first    = (r_cnt == '0);
    assign w_last     = (r_cnt == c_LAST);
    // The order bit is taken live on the first bit, latched for the rest.
    assign w_ord      = w_first ? msb_first : r_ord;
    assign w_complete = w_accept & w_last;
    assign w_drain    = r_p_valid & p_ready;
    // A finished word lands if the buffer is empty or empties on this edge.
    assign w_load     = w_complete & (~r_p_valid | p_ready);

    assign w_sr_shifted = w_ord ? {r_sr[N-2:0], s_in} : {s_in, r_sr[N-1:1]};

`ifdef SER_RX_PARITY_EN
    logic r_parity_err;
    logic w_parity_err;

    // The trailing parity bit is checked but never shifted into the word.
    assign w_shift_data = w_accept & ~w_last;
    assign w_word       = r_sr;
    assign w_parity_err = (^r_sr) ^ s_in;
    assign parity_err   = r_parity_err;
`else
    // Without parity the final data bit completes the word on the same edge.
    assign w_shift_data = w_accept;
    assign w_word       = w_sr_shifted;
`endif

    // Shift register, bit counter and per-word order latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_ord <= 1'b1;
        end else if (flush) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_ord <= msb_first;
            end
            if (w_shift_data) begin
                r_sr <= w_sr_shifted;
            end
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Holding buffer: load on completion, release on drain, sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_out      <= '0;
            r_p_valid    <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SER_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_p_out      <= w_word;
                r_p_valid    <= 1'b1;
`ifdef SER_RX_PARITY_EN
                r_parity_err <= w_parity_err;
`endif
            end else if (w_drain) begin
                r_p_valid <= 1'b0;
            end

            if (flush) begin
                r_overrun <= 1'b0;
            end else if (w_complete && !w_load) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign p_out   = r_p_out;
    assign p_valid = r_p_valid;
    assign overrun = r_overrun;
    assign busy    = (r_cnt != '0);

endmodule
`default_nettype wire
